// File: rtl/mont_pkg.sv
// Shared Montgomery definitions: controller states, default operand width and
// the iteration counter width helper.
package mont_pkg;

    localparam int unsigned MontLenDefault = 2048;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } mont_state_e;

    // 2*len doubling iterations plus headroom for the terminal count.
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(2 * len + 1);
    endfunction

endpackage

// File: rtl/mont_dbl_mod.sv
// One modular doubling step r -> 2r mod n; requires r < n on entry.
module mont_dbl_mod
    import mont_pkg::*;
#(
    parameter int unsigned LEN = MontLenDefault
) (
    input  logic [LEN:0]   i_r,
    input  logic [LEN-1:0] i_n,
    output logic [LEN:0]   o_r
);

    logic [LEN:0] w_r2x;
    logic [LEN:0] w_n_ext;

    // r < n < 2^LEN, so the shifted-out top bit is always zero.
    assign w_r2x   = i_r << 1;
    assign w_n_ext = {1'b0, i_n};
    assign o_r     = (w_r2x >= w_n_ext) ? (w_r2x - w_n_ext) : w_r2x;

endmodule

// File: rtl/mont_precompute.sv
// Bit-serial Montgomery constants: n_prime = -n^-1 mod 2^LEN, r2_mod_n = 2^(2LEN) mod n.
// Define MONT_PRECOMP_R1_EN to also produce r_mod_n = 2^LEN mod n.
module mont_precompute
    import mont_pkg::*;
#(
    parameter int unsigned LEN = MontLenDefault
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] n,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [LEN-1:0] n_prime,
    output logic [LEN-1:0] r2_mod_n,
    output logic [LEN-1:0] r_mod_n
);

    localparam int unsigned CNTW = cnt_width(LEN);
    localparam int unsigned IDXW = $clog2(LEN);
    localparam logic [CNTW-1:0] CntLast = CNTW'(2 * LEN - 1);
    localparam logic [CNTW-1:0] CntLen  = CNTW'(LEN);

    mont_state_e     r_state;
    logic [LEN-1:0]  r_n_q;
    logic [LEN-1:0]  r_y;
    logic [LEN-1:0]  r_t;
    logic [LEN:0]    r_r;
    logic [CNTW-1:0] r_cnt;
    logic            r_err_q;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [LEN-1:0]  r_n_prime;
    logic [LEN-1:0]  r_r2;

    logic [LEN:0]    w_r_dbl;
    logic [IDXW-1:0] w_idx;
    logic            w_inv_step;

    mont_dbl_mod #(
        .LEN (LEN)
    ) u_dbl (
        .i_r (r_r),
        .i_n (r_n_q),
        .o_r (w_r_dbl)
    );

    assign w_idx      = r_cnt[IDXW-1:0];
    assign w_inv_step = (r_cnt != '0) && (r_cnt < CntLen) && r_t[w_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_n_q     <= '0;
            r_y       <= '0;
            r_t       <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
            r_err_q   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_n_prime <= '0;
            r_r2      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_n_q <= n;
                        r_cnt <= '0;
                        if (n[0]) begin
                            r_y     <= LEN'(1);
                            r_t     <= n;
                            r_r     <= {{LEN{1'b0}}, (n != LEN'(1))};
                            r_err_q <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= StRun;
                        end else begin
                            r_err_q <= 1'b1;
                            r_state <= StFin;
                        end
                    end
                end
                StRun: begin
                    r_r <= w_r_dbl;
                    // Clear bit i of t = n*y by adding n<<i, recording 2^i in y.
                    if (w_inv_step) begin
                        r_y[w_idx] <= 1'b1;
                        r_t        <= r_t + (r_n_q << w_idx);
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        r_state <= StFin;
                    end
                end
                StFin: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_err   <= r_err_q;
                    r_state <= StIdle;
                    if (r_err_q) begin
                        r_n_prime <= '0;
                        r_r2      <= '0;
                    end else begin
                        r_n_prime <= ~r_y + LEN'(1);
                        r_r2      <= r_r[LEN-1:0];
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef MONT_PRECOMP_R1_EN
    localparam logic [CNTW-1:0] CntR1 = CNTW'(LEN - 1);

    logic [LEN-1:0] r_r1_cap;
    logic [LEN-1:0] r_r1_out;

    // Captured mid-run, published only at completion so outputs hold while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r1_cap <= '0;
            r_r1_out <= '0;
        end else begin
            if (r_state == StRun && r_cnt == CntR1) begin
                r_r1_cap <= w_r_dbl[LEN-1:0];
            end
            if (r_state == StFin) begin
                r_r1_out <= r_err_q ? '0 : r_r1_cap;
            end
        end
    end

    assign r_mod_n = r_r1_out;
`else
    assign r_mod_n = '0;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign n_prime  = r_n_prime;
    assign r2_mod_n = r_r2;

endmodule

// File: tb/tb_mont_precompute.sv
// Scoreboard bench for mont_precompute at LEN=8 with a brute-force arithmetic reference.
module tb_mont_precompute;

    localparam int unsigned LEN = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [LEN-1:0] n;
    logic           busy;
    logic           done;
    logic           err;
    logic [LEN-1:0] n_prime;
    logic [LEN-1:0] r2_mod_n;
    logic [LEN-1:0] r_mod_n;

    mont_precompute #(
        .LEN (LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .n_prime  (n_prime),
        .r2_mod_n (r2_mod_n),
        .r_mod_n  (r_mod_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LEN-1:0] np;
        logic [LEN-1:0] r2;
        logic [LEN-1:0] r1;
        logic           er;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input longint act, input longint want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: search the inverse directly, reduce powers of two with plain modulo.
    function automatic exp_t model(input logic [LEN-1:0] nv);
        exp_t   e;
        longint m;
        longint nn;
        e  = '0;
        m  = longint'(1) << LEN;
        nn = longint'(nv);
        if (nv[0] == 1'b0) begin
            e.er = 1'b1;
            return e;
        end
        for (longint y = 1; y < m; y += 2) begin
            if ((nn * y) % m == 1) e.np = LEN'((m - y) % m);
        end
        e.r2 = LEN'((longint'(1) << (2 * LEN)) % nn);
`ifdef MONT_PRECOMP_R1_EN
        e.r1 = LEN'(m % nn);
`endif
        return e;
    endfunction

    // Monitor: pops on every done, and checks outputs hold while busy.
    logic           p_busy = 1'b0;
    logic [LEN-1:0] p_np, p_r2, p_r1;
    logic           p_err;

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("n_prime", longint'(n_prime), longint'(e.np));
                chk("r2_mod_n", longint'(r2_mod_n), longint'(e.r2));
                chk("r_mod_n", longint'(r_mod_n), longint'(e.r1));
                chk("err", longint'(err), longint'(e.er));
                chk("busy_low_at_done", longint'(busy), 0);
            end
        end
        if (!rst && p_busy && busy) begin
            chk("hold_n_prime", longint'(n_prime), longint'(p_np));
            chk("hold_r2_mod_n", longint'(r2_mod_n), longint'(p_r2));
            chk("hold_err", longint'(err), longint'(p_err));
        end
        p_busy <= busy && !rst;
        p_np   <= n_prime;
        p_r2   <= r2_mod_n;
        p_r1   <= r_mod_n;
        p_err  <= err;
    end

    // Waits (bounded) for done after an accept edge; returns cycles, 0 on timeout.
    task automatic wait_done(input logic odd, output int lat);
        lat = 0;
        for (int k = 1; k <= 4 * LEN && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
            else if (!odd) chk("even_busy_low", longint'(busy), 0);
        end
    endtask

    task automatic run_op(input logic [LEN-1:0] nv);
        int lat;
        @(negedge clk);
        start = 1'b1;
        n     = nv;
        @(posedge clk);
        exp_q.push_back(model(nv));
        #1;
        start = 1'b0;
        n     = LEN'($urandom);
        chk("busy_after_start", longint'(busy), longint'(nv[0]));
        wait_done(nv[0], lat);
        chk("latency", lat, nv[0] ? 2 * LEN + 1 : 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_n_prime", longint'(n_prime), 0);
        chk("rst_r2_mod_n", longint'(r2_mod_n), 0);
        chk("rst_r_mod_n", longint'(r_mod_n), 0);
        rst = 1'b0;

        run_op(8'hC5);
        run_op(8'h0F);
        run_op(8'h01);
        run_op(8'h00);
        run_op(8'hC4);
        run_op(8'hFF);

        // Start held high: 0x0F then restart with 0xFF right after FIN.
        @(negedge clk);
        start = 1'b1;
        n     = 8'h0F;
        @(posedge clk);
        exp_q.push_back(model(8'h0F));
        #1;
        n = 8'hFF;
        wait_done(1'b1, lat);
        chk("b2b_latency_first", lat, 2 * LEN + 1);
        @(posedge clk);
        exp_q.push_back(model(8'hFF));
        #1;
        start = 1'b0;
        chk("b2b_restart_busy", longint'(busy), 1);
        wait_done(1'b1, lat);
        chk("b2b_latency_second", lat, 2 * LEN + 1);

        // Start pulse and n change while busy are ignored.
        @(negedge clk);
        start = 1'b1;
        n     = 8'hC5;
        @(posedge clk);
        exp_q.push_back(model(8'hC5));
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n = 8'h0F;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int k = 6; k <= 4 * LEN && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        chk("ignored_start_latency", lat, 2 * LEN + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_start_no_rerun", longint'(busy), 0);

        // Reset mid-operation aborts without done.
        @(negedge clk);
        start = 1'b1;
        n     = 8'hC5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_n_prime", longint'(n_prime), 0);
        chk("abort_r2_mod_n", longint'(r2_mod_n), 0);
        chk("abort_r_mod_n", longint'(r_mod_n), 0);
        repeat (2 * LEN + 4) @(posedge clk);
        #1;
        chk("abort_still_idle", longint'(busy), 0);
        run_op(8'hC5);

        for (int i = 0; i < 40; i++) begin
            run_op(LEN'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        chk("queue_empty", longint'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
